// File: rtl/dma_pkg.sv
// Shared constants, FSM state type and helpers for the line-copy DMA controller.
// Contents:
//   WORD_SIZE, LINE_WORDS, NUM_LINES, ADDR_WIDTH, OFFSET_WIDTH, LINE_WIDTH
//   OFFSET_IDLE   device offset value driven whenever no line is being loaded
//   dma_state_e   controller states (REL only reachable with DMA_CYCLE_STEAL_EN)
//   clamp_len()   limits a requested line count to what the device holds
package dma_pkg;

  localparam int unsigned WORD_SIZE    = 16;
  localparam int unsigned LINE_WORDS   = 4;
  localparam int unsigned NUM_LINES    = 3;
  localparam int unsigned ADDR_WIDTH   = 16;
  localparam int unsigned OFFSET_WIDTH = 2;
  localparam int unsigned LINE_WIDTH   = LINE_WORDS * WORD_SIZE;

  localparam logic [OFFSET_WIDTH-1:0] OFFSET_IDLE = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSel,
    StCap,
    StWr,
    StRel,
    StDone
  } dma_state_e;

  function automatic logic [OFFSET_WIDTH-1:0] clamp_len(input logic [OFFSET_WIDTH-1:0] len);
    if ({{(32 - OFFSET_WIDTH){1'b0}}, len} > NUM_LINES) begin
      return OFFSET_WIDTH'(NUM_LINES);
    end
    return len;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Line counter and destination address generator.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   load          capture load_addr/load_len, clear line counter
//   step          advance to next line: addr += LINE_WORDS, line++
//   load_addr     destination word address of line 0
//   load_len      number of lines in this transfer (already clamped)
//   addr          current line's memory word address (wraps mod 2^ADDR_WIDTH)
//   line          current line index (device offset)
//   line_next     line + 1
//   last          current line is the final one of the transfer
module dma_addr_gen
  import dma_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    step,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [OFFSET_WIDTH-1:0] load_len,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [OFFSET_WIDTH-1:0] line,
  output logic [OFFSET_WIDTH-1:0] line_next,
  output logic                    last
);

  logic [OFFSET_WIDTH-1:0] len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr  <= '0;
      line  <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= load_addr;
      line  <= '0;
      len_q <= load_len;
    end else if (step) begin
      addr <= addr + ADDR_WIDTH'(LINE_WORDS);
      line <= line_next;
    end
  end

  assign line_next = line + OFFSET_WIDTH'(1);
  assign last      = (line_next == len_q);

endmodule

// File: rtl/dma_controller.sv
// Line-copy DMA controller: takes a CPU command, arbitrates for the bus, selects
// each device line by offset, captures it and writes it to memory, then pulses
// dma_done once the last line has been acknowledged.
// Configuration macro: DMA_CYCLE_STEAL_EN
//   defined   - bus_request drops for one cycle (REL) after every non-final line
//   undefined - bus_request held from first request until DONE
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cmd_valid/cmd_addr/cmd_length CPU command; cmd_ready high only in IDLE
//   bus_request/bus_grant         BR/BG handshake with the CPU
//   offset/dev_data               device line select (2'b11 idle) and line data
//   mem_addr/mem_wdata/mem_write  line write to memory, held until mem_ack
//   mem_ack                       1-cycle write-complete pulse
//   dma_done                      1-cycle completion pulse
module dma_controller
  import dma_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [OFFSET_WIDTH-1:0] cmd_length,
  output logic                    cmd_ready,
  output logic                    bus_request,
  input  logic                    bus_grant,
  output logic [OFFSET_WIDTH-1:0] offset,
  input  logic [LINE_WIDTH-1:0]   dev_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_WIDTH-1:0]   mem_wdata,
  output logic                    mem_write,
  input  logic                    mem_ack,
  output logic                    dma_done
);

  dma_state_e              state_q;
  logic                    ag_load;
  logic                    ag_step;
  logic [OFFSET_WIDTH-1:0] len_clamped;
  logic [OFFSET_WIDTH-1:0] line;
  logic [OFFSET_WIDTH-1:0] line_next;
  logic                    last;

  assign len_clamped = clamp_len(cmd_length);
  assign ag_load     = (state_q == StIdle) && cmd_valid;
  assign ag_step     = (state_q == StWr) && mem_ack;

  dma_addr_gen u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ag_load),
    .step      (ag_step),
    .load_addr (cmd_addr),
    .load_len  (len_clamped),
    .addr      (mem_addr),
    .line      (line),
    .line_next (line_next),
    .last      (last)
  );

  // All outputs are registered and updated on the transition into the state
  // that owns them, so each output reflects the current state without glue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cmd_ready   <= 1'b1;
      bus_request <= 1'b0;
      offset      <= OFFSET_IDLE;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      dma_done    <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (len_clamped == '0) begin
              state_q  <= StDone;
              dma_done <= 1'b1;
            end else begin
              state_q     <= StReq;
              bus_request <= 1'b1;
            end
          end
        end
        StReq: begin
          if (bus_grant) begin
            state_q <= StSel;
            offset  <= line;
          end
        end
        // Device output settles one cycle after offset changes.
        StSel: state_q <= StCap;
        StCap: begin
          mem_wdata <= dev_data;
          mem_write <= 1'b1;
          offset    <= OFFSET_IDLE;
          state_q   <= StWr;
        end
        // Grant is deliberately not checked until the line has been written.
        StWr: begin
          if (mem_ack) begin
            mem_write <= 1'b0;
            if (last) begin
              state_q     <= StDone;
              bus_request <= 1'b0;
              dma_done    <= 1'b1;
            end else begin
`ifdef DMA_CYCLE_STEAL_EN
              state_q     <= StRel;
              bus_request <= 1'b0;
`else
              if (!bus_grant) begin
                state_q <= StReq;
              end else begin
                state_q <= StSel;
                offset  <= line_next;
              end
`endif
            end
          end
        end
`ifdef DMA_CYCLE_STEAL_EN
        StRel: begin
          state_q     <= StReq;
          bus_request <= 1'b1;
        end
`endif
        StDone: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready   <= 1'b1;
          bus_request <= 1'b0;
          offset      <= OFFSET_IDLE;
          mem_write   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed testbench for dma_controller with a CPU grant model, a device line
// store (one-cycle settle) and a memory responder that logs every line write.
module tb_dma_controller;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_length;
  logic        cmd_ready;
  logic        bus_request;
  logic        bus_grant;
  logic [1:0]  offset;
  logic [63:0] dev_data;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_ack;
  logic        dma_done;

  dma_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_length  (cmd_length),
    .cmd_ready   (cmd_ready),
    .bus_request (bus_request),
    .bus_grant   (bus_grant),
    .offset      (offset),
    .dev_data    (dev_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_ack     (mem_ack),
    .dma_done    (dma_done)
  );

  localparam int GRANT_DELAY = 2;
  localparam int ACK_DELAY   = 1;
`ifdef DMA_CYCLE_STEAL_EN
  localparam int EXP_BR_LOW_3 = 2;
  localparam int EXP_BR_RISE_3 = 3;
`else
  localparam int EXP_BR_LOW_3 = 0;
  localparam int EXP_BR_RISE_3 = 1;
`endif

  logic [63:0] storage [0:2];
  logic [15:0] wr_addr [$];
  logic [63:0] wr_data [$];

  int n_cmp;
  int n_err;
  int done_cnt;
  int br_rises;
  int br_low;
  int gcnt;
  int acnt;
  bit in_xfer;
  bit br_prev;
  bit grant_hold;
  bit ack_hold;
  bit timed_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device: line appears on dev_data one cycle after offset selects it.
  always @(posedge clk) begin
    dev_data <= (offset < 2'd3) ? storage[offset] : 64'h0;
  end

  // Monitor, CPU grant model and memory responder, all on the falling edge.
  always @(negedge clk) begin
    if (dma_done) begin
      done_cnt++;
      in_xfer = 1'b0;
    end
    if (bus_request) begin
      if (!br_prev) br_rises++;
      in_xfer = 1'b1;
    end else if (in_xfer) begin
      br_low++;
    end
    br_prev = bus_request;

    if (!bus_request) begin
      bus_grant = 1'b0;
      gcnt      = 0;
    end else begin
      if (gcnt < GRANT_DELAY) gcnt++;
      bus_grant = (gcnt >= GRANT_DELAY) && !grant_hold;
    end

    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_write && !ack_hold) begin
      if (acnt == ACK_DELAY) begin
        mem_ack = 1'b1;
        acnt    = 0;
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end else begin
        acnt++;
      end
    end else begin
      acnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    done_cnt = 0;
    br_rises = 0;
    br_low   = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Issue one command; optionally keep a bogus command asserted while busy.
  task automatic start_cmd(input logic [15:0] a, input logic [1:0] len, input int pokes);
    @(posedge clk); #1;
    clear_logs();
    check_eq("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_length = len;
    @(posedge clk); #1;
    for (int i = 0; i < pokes; i++) begin
      cmd_addr   = 16'h0BAD;
      cmd_length = 2'd3;
      check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_timeout"}, 64'(timed_out), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_mem_write(input string tag);
    timed_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (mem_write) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_eq({tag, "_wr_timeout"}, 64'(timed_out), 64'd0);
  endtask

  task automatic expect_writes(input string tag, input logic [15:0] base, input int len);
    logic [15:0] a;
    check_eq({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(len));
    a = base;
    for (int i = 0; i < len; i++) begin
      if (i < wr_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(a));
        check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], storage[i]);
      end
      a = a + 16'd4;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    storage[0] = 64'h0123_4567_89AB_CDEF;
    storage[1] = 64'hA5A5_5A5A_F00D_BEEF;
    storage[2] = 64'h1111_2222_3333_4444;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = 16'h0;
    cmd_length = 2'd0;
    bus_grant  = 1'b0;
    mem_ack    = 1'b0;
    grant_hold = 1'b0;
    ack_hold   = 1'b0;
    gcnt = 0;
    acnt = 0;
    in_xfer = 1'b0;
    br_prev = 1'b0;
    clear_logs();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_bus_request", 64'(bus_request), 64'd0);
    check_eq("rst_offset", 64'(offset), 64'd3);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_mem_write", 64'(mem_write), 64'd0);
    check_eq("rst_dma_done", 64'(dma_done), 64'd0);
    reset_n = 1'b1;

    // 1: three lines from 0x01F0
    start_cmd(16'h01F0, 2'd3, 0);
    wait_done("t1");
    expect_writes("t1", 16'h01F0, 3);
    check_eq("t1_done_count", 64'(done_cnt), 64'd1);
    check_eq("t1_br_low_after", 64'(bus_request), 64'd0);
    check_eq("t1_cmd_ready_after", 64'(cmd_ready), 64'd1);
    check_eq("t1_offset_idle", 64'(offset), 64'd3);
    check_eq("t1_br_low_cycles", 64'(br_low), 64'(EXP_BR_LOW_3));
    check_eq("t1_br_rises", 64'(br_rises), 64'(EXP_BR_RISE_3));

    // 2: zero-length command completes without a bus request
    start_cmd(16'h0040, 2'd0, 0);
    check_eq("t2_done_next_cycle", 64'(dma_done), 64'd1);
    @(posedge clk); #1;
    check_eq("t2_done_one_cycle", 64'(dma_done), 64'd0);
    check_eq("t2_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("t2_br_rises", 64'(br_rises), 64'd0);
    check_eq("t2_done_count", 64'(done_cnt), 64'd1);
    check_eq("t2_nwrites", 64'(wr_addr.size()), 64'd0);

    // 3: address wrap
    start_cmd(16'hFFFC, 2'd2, 0);
    wait_done("t3");
    expect_writes("t3", 16'hFFFC, 2);
    if (wr_addr.size() > 1) check_eq("t3_wrap_addr", 64'(wr_addr[1]), 64'h0);
    check_eq("t3_mem_addr_end", 64'(mem_addr), 64'h0004);

    // 4: grant withdrawn during the first line's write
    start_cmd(16'h0100, 2'd3, 0);
    wait_mem_write("t4");
    grant_hold = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t4_br_held", 64'(bus_request), 64'd1);
    check_eq("t4_waiting_no_write", 64'(mem_write), 64'd0);
    check_eq("t4_waiting_offset", 64'(offset), 64'd3);
    check_eq("t4_one_line_done", 64'(wr_addr.size()), 64'd1);
    grant_hold = 1'b0;
    @(posedge clk); #1;
    check_eq("t4_resume_offset", 64'(offset), 64'd1);
    wait_done("t4");
    expect_writes("t4", 16'h0100, 3);
    check_eq("t4_br_low_cycles", 64'(br_low), 64'(EXP_BR_LOW_3));

    // 5: reset while a write waits for its ack
    ack_hold = 1'b1;
    start_cmd(16'h0200, 2'd2, 0);
    wait_mem_write("t5");
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_mem_write", 64'(mem_write), 64'd0);
    check_eq("t5_rst_bus_request", 64'(bus_request), 64'd0);
    check_eq("t5_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("t5_rst_offset", 64'(offset), 64'd3);
    check_eq("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n  = 1'b1;
    ack_hold = 1'b0;
    start_cmd(16'h0300, 2'd2, 0);
    wait_done("t5");
    expect_writes("t5", 16'h0300, 2);

    // 6: command while busy is ignored
    start_cmd(16'h0400, 2'd1, 3);
    wait_done("t6");
    expect_writes("t6", 16'h0400, 1);
    check_eq("t6_done_count", 64'(done_cnt), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_no_second_xfer", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
